// File: rtl/control_unit_pkg.sv
// control_unit_pkg: Mini SRC opcodes, step encodings and instruction classes
package control_unit_pkg;
    localparam int OP_W = 5;
    typedef logic [OP_W-1:0] op_t;
    localparam op_t OP_LD   = 5'b00000;
    localparam op_t OP_LDI  = 5'b00001;
    localparam op_t OP_ST   = 5'b00010;
    localparam op_t OP_ADD  = 5'b00011;
    localparam op_t OP_SHL  = 5'b01011;
    localparam op_t OP_ADDI = 5'b01100;
    localparam op_t OP_ANDI = 5'b01101;
    localparam op_t OP_ORI  = 5'b01110;
    localparam op_t OP_DIV  = 5'b01111;
    localparam op_t OP_MUL  = 5'b10000;
    localparam op_t OP_NEG  = 5'b10001;
    localparam op_t OP_NOT  = 5'b10010;
    localparam op_t OP_BR   = 5'b10011;
    localparam op_t OP_JR   = 5'b10100;
    localparam op_t OP_IN   = 5'b10110;
    localparam op_t OP_OUT  = 5'b10111;
    localparam op_t OP_MFHI = 5'b11000;
    localparam op_t OP_MFLO = 5'b11001;
    localparam op_t OP_NOP  = 5'b11010;
    localparam op_t OP_HALT = 5'b11011;
    localparam op_t NOP_OP  = OP_NOP;
    typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} step_t;
    typedef struct packed {
        logic ld;
        logic ldi;
        logic st;
        logic alu_r;
        logic alu_i;
        logic unary;
        logic br;
        logic jr;
        logic io_in;
        logic io_out;
        logic mfhi;
        logic mflo;
        logic muldiv;
        logic halt;
        logic none;
    } cls_t;
endpackage

// File: rtl/instr_class_decode.sv
// instr_class_decode: opcode to one-hot instruction class (mul/div only with MULDIV_EN)
module instr_class_decode
    import control_unit_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output cls_t            cls
);
    always_comb begin
        cls = '0;
        cls.ld = op == OP_LD;
        cls.ldi = op == OP_LDI;
        cls.st = op == OP_ST;
        cls.alu_r = op >= OP_ADD && op <= OP_SHL;
        cls.alu_i = op inside {OP_ADDI, OP_ANDI, OP_ORI};
        cls.unary = op inside {OP_NEG, OP_NOT};
        cls.br = op == OP_BR;
        cls.jr = op == OP_JR;
        cls.io_in = op == OP_IN;
        cls.io_out = op == OP_OUT;
        cls.mfhi = op == OP_MFHI;
        cls.mflo = op == OP_MFLO;
`ifdef MULDIV_EN
        cls.muldiv = op inside {OP_MUL, OP_DIV};
`else
        cls.muldiv = 1'b0;
`endif
        cls.halt = op == OP_HALT;
        cls.none = ~|cls[14:1];
    end
endmodule

// File: rtl/control_unit.sv
// control_unit: Mini SRC hardwired control sequencer; define MULDIV_EN to execute mul/div
module control_unit
    import control_unit_pkg::*;
(
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     ir,
    input  logic            CON_FF,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic            PCout,
    output logic            IncPC,
    output logic            PCin,
    output logic            IRin,
    output logic            Yin,
    output logic            HIout,
    output logic            HIin,
    output logic            LOout,
    output logic            LOin,
    output logic            Cout,
    output logic            Zhighout,
    output logic            Zlowout,
    output logic            Zin,
    output logic            MDRout,
    output logic            MDRin,
    output logic            MARin,
    output logic            memRead,
    output logic            memWrite,
    output logic            CONin,
    output logic            inPortOut,
    output logic            outPort_en,
    output logic [OP_W-1:0] opcode,
    output logic            run
);
    step_t step, nxt, last;
    cls_t cls;
    logic [7:0] t;
    logic addr, alu, ir_unused;
    assign ir_unused = ^ir[26:0];
    instr_class_decode u_decode (
        .op (ir[31:27]),
        .cls(cls)
    );
    always_ff @(posedge clock or posedge clear) begin
        if (clear) step <= T0;
        else step <= nxt;
    end
    always_comb begin
        last = cls.none ? T3 : (cls.ld | cls.st) ? T7 : (cls.br | cls.muldiv) ? T6 :
               (cls.ldi | cls.alu_r | cls.alu_i) ? T5 : cls.unary ? T4 : T3;
        nxt = step_t'(step + 4'd1);
        if (step == HALT) nxt = HALT;
        else if (step >= T3 && step >= last) nxt = cls.halt ? HALT : T0;
    end
    // every strobe is qualified by a step bit, so clearing t silences them all
    always_comb begin
        t = '0;
        t[step[2:0]] = !clear && step != HALT;
        addr = cls.ld | cls.ldi | cls.st;
        alu = cls.alu_r | cls.alu_i;
        run = clear || step != HALT;
        Gra = t[3] & (cls.br | cls.jr | cls.io_in | cls.io_out | cls.mfhi | cls.mflo | cls.muldiv)
            | t[4] & cls.unary | t[5] & (cls.ldi | alu) | t[6] & cls.st | t[7] & cls.ld;
        Grb = t[3] & (addr | alu | cls.unary) | t[4] & cls.muldiv;
        Grc = t[4] & cls.alu_r;
        Rin = t[3] & (cls.io_in | cls.mfhi | cls.mflo) | t[4] & cls.unary
            | t[5] & (cls.ldi | alu) | t[7] & cls.ld;
        Rout = t[3] & (alu | cls.unary | cls.br | cls.jr | cls.io_out | cls.muldiv)
             | t[4] & (cls.alu_r | cls.muldiv) | t[6] & cls.st;
        BAout = t[3] & addr;
        PCout = t[0] | t[4] & cls.br;
        IncPC = t[0];
        PCin = t[1] | t[3] & cls.jr | t[6] & cls.br & CON_FF;
        IRin = t[2];
        Yin = t[3] & (addr | alu | cls.muldiv) | t[4] & cls.br;
        HIout = t[3] & cls.mfhi;
        HIin = t[6] & cls.muldiv;
        LOout = t[3] & cls.mflo;
        LOin = t[5] & cls.muldiv;
        Cout = t[4] & (addr | cls.alu_i) | t[5] & cls.br;
        Zhighout = t[6] & cls.muldiv;
        Zlowout = t[1] | t[4] & cls.unary | t[5] & (addr | alu | cls.muldiv) | t[6] & cls.br;
        Zin = t[0] | t[3] & cls.unary | t[4] & (addr | alu | cls.muldiv) | t[5] & cls.br;
        MDRout = t[2] | t[7] & cls.ld;
        MDRin = t[1] | t[6] & (cls.ld | cls.st);
        MARin = t[0] | t[5] & (cls.ld | cls.st);
        memRead = t[1] | t[6] & cls.ld;
        memWrite = t[7] & cls.st;
        CONin = t[3] & cls.br;
        inPortOut = t[3] & cls.io_in;
        outPort_en = t[3] & cls.io_out;
        opcode = (t[4] & addr | t[5] & cls.br) ? OP_ADD :
                 (t[4] & (alu | cls.muldiv) | t[3] & cls.unary) ? ir[31:27] : NOP_OP;
    end
endmodule
